// File: rtl/result_hex_sequencer.sv
// -----------------------------------------------------------------------------
// result_hex_sequencer
//
// Shows an 8-bit ALU result on a single 7-segment digit as a time sequence.
// The high nibble is shown first with the decimal point lit, then the low
// nibble, then a blank gap, and the cycle repeats. The result is captured on a
// load strobe, so the display stays stable while the operand switches move.
//
// Parameters:
//   DWELL_CYCLES : clock cycles each digit is shown (>= 1)
//   BLANK_CYCLES : clock cycles of blank gap after the low digit (>= 1)
//   CNT_W        : phase counter width, holds max(DWELL,BLANK)-1
//
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   ena       : enable; low freezes sequencing and blanks the display
//   load      : single-cycle capture strobe for result_in
//   result_in : ALU result to display
//   seg_out   : segments, [6:0] = a..g active high, [7] = decimal point
//   phase     : current state, 0=IDLE 1=SHOW_HI 2=SHOW_LO 3=GAP
// -----------------------------------------------------------------------------
module result_hex_sequencer #(
   parameter int DWELL_CYCLES = 5000000,
   parameter int BLANK_CYCLES = 1000000,
   parameter int CNT_W        = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       load,
   input  logic [7:0] result_in,
   output logic [7:0] seg_out,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHOW_HI = 2'd1,
      SHOW_LO = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state;
   logic [7:0]       held;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       seg_next;
   logic             cnt_last;

   // Hex digit to segments a..g (bit 0 = a).
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // Display pattern for the current state; registered below so it lags the state by one edge.
   always_comb begin
      seg_next = 8'h00;
      case (state)
         IDLE:    seg_next = 8'h40;
         SHOW_HI: seg_next = {1'b1, hex7(held[7:4])};
         SHOW_LO: seg_next = {1'b0, hex7(held[3:0])};
         GAP:     seg_next = 8'h00;
         default: seg_next = 8'h00;
      endcase
   end

   // Terminal-count detect for the phase the FSM is currently in.
   always_comb begin
      cnt_last = 1'b0;
      case (state)
         SHOW_HI: cnt_last = (cnt == DWELL_LAST);
         SHOW_LO: cnt_last = (cnt == DWELL_LAST);
         GAP:     cnt_last = (cnt == BLANK_LAST);
         default: cnt_last = 1'b0;
      endcase
   end

   // Sequencer FSM: capture, phase timing and registered segment output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         held    <= 8'h00;
         cnt     <= CNT_ZERO;
         seg_out <= 8'h00;
      end else if (ena) begin
         seg_out <= seg_next;
         if (load) begin
            // A load restarts the sequence and overrides any expiry this edge.
            held  <= result_in;
            state <= SHOW_HI;
            cnt   <= CNT_ZERO;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= CNT_ZERO;
               end
               SHOW_HI: begin
                  if (cnt_last) begin
                     state <= SHOW_LO;
                     cnt   <= CNT_ZERO;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               SHOW_LO: begin
                  if (cnt_last) begin
                     state <= GAP;
                     cnt   <= CNT_ZERO;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               GAP: begin
                  if (cnt_last) begin
                     state <= SHOW_HI;
                     cnt   <= CNT_ZERO;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= CNT_ZERO;
               end
            endcase
         end
      end else begin
         // Disabled: state and counter hold, display goes dark.
         seg_out <= 8'h00;
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_result_hex_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for result_hex_sequencer (DWELL_CYCLES=4, BLANK_CYCLES=2).
// A behavioural model tracks the shown phase and the cycles remaining in it;
// every edge the DUT's seg_out and phase are compared against it, and key
// points of the directed scenarios are also compared against literal values.
// -----------------------------------------------------------------------------
module tb_result_hex_sequencer;

   localparam int DW = 4;
   localparam int BK = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       load;
   logic [7:0] result_in;
   logic [7:0] seg_out;
   logic [1:0] phase;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int         m_phase;
   int         m_rem;
   logic [7:0] m_held;
   logic [7:0] m_seg;

   logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   result_hex_sequencer #(
      .DWELL_CYCLES(DW),
      .BLANK_CYCLES(BK),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .load(load),
      .result_in(result_in),
      .seg_out(seg_out),
      .phase(phase)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pattern(input int ph, input logic [7:0] h);
      case (ph)
         0:       return 8'h40;
         1:       return hex_tab[h[7:4]] | 8'h80;
         2:       return hex_tab[h[3:0]];
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_rem   = 0;
      m_held  = 8'h00;
      m_seg   = 8'h00;
   endtask

   // One clock edge: drive inputs, advance the model, compare after the edge.
   task automatic step(input logic e, input logic l, input logic [7:0] d);
      logic [7:0] ns;
      ena       = e;
      load      = l;
      result_in = d;
      @(posedge clk);
      ns = e ? pattern(m_phase, m_held) : 8'h00;
      if (e) begin
         if (l) begin
            m_held  = d;
            m_phase = 1;
            m_rem   = DW;
         end else if (m_phase != 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_phase = (m_phase == 3) ? 1 : m_phase + 1;
               m_rem   = (m_phase == 3) ? BK : DW;
            end
         end
      end
      m_seg = ns;
      #1;
      check("seg_model", seg_out, m_seg);
      check("phase_model", {6'd0, phase}, 8'(m_phase));
      load = 1'b0;
   endtask

   // Async reset asserted between edges, checked before any edge, then released.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_seg", seg_out, 8'h00);
      check("rst_phase", {6'd0, phase}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] exp2 [11] = '{8'hCF, 8'hCF, 8'hCF, 8'hCF, 8'h39, 8'h39, 8'h39, 8'h39,
                                8'h00, 8'h00, 8'hCF};
      logic [7:0] v;
      rst_n     = 1'b1;
      ena       = 1'b0;
      load      = 1'b0;
      result_in = 8'h00;
      model_reset();

      // 1. Reset then idle.
      async_reset();
      step(1'b1, 1'b0, 8'h00);
      check("idle_dash", seg_out, 8'h40);
      step(1'b1, 1'b0, 8'h00);
      check("idle_phase", {6'd0, phase}, 8'h00);

      // 2. Basic sequence with 0x3C.
      step(1'b1, 1'b1, 8'h3C);
      check("load_phase", {6'd0, phase}, 8'h01);
      check("load_lag", seg_out, 8'h40);
      for (int i = 0; i < 11; i++) begin
         step(1'b1, 1'b0, 8'h00);
         check($sformatf("seq_%0d", i), seg_out, exp2[i]);
      end

      // 3. Reload 0xA5 during the second cycle of the low digit.
      step(1'b1, 1'b1, 8'h3C);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00);
      check("lo_shown", seg_out, 8'h39);
      step(1'b1, 1'b1, 8'hA5);
      check("reload_phase", {6'd0, phase}, 8'h01);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'h00);
         check($sformatf("a5_%0d", i), seg_out, (i < 4) ? 8'hF7 : 8'h6D);
      end

      // 4. Load on the final GAP cycle: full high-digit dwell follows.
      step(1'b1, 1'b0, 8'h00);
      check("gap_phase", {6'd0, phase}, 8'h03);
      step(1'b1, 1'b1, 8'h0F);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 8'h00);
         check($sformatf("f0_%0d", i), seg_out, (i < 4) ? 8'hBF : 8'h71);
      end

      // 5. Enable gating after two SHOW_HI cycles, with an ignored load.
      v = 8'(($urandom_range(0, 254)));
      step(1'b1, 1'b1, v);
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, (i == 2), ~v);
         check($sformatf("gate_seg_%0d", i), seg_out, 8'h00);
         check($sformatf("gate_ph_%0d", i), {6'd0, phase}, 8'h01);
      end
      step(1'b1, 1'b0, 8'h00);
      check("resume_hi0", seg_out, hex_tab[v[7:4]] | 8'h80);
      step(1'b1, 1'b0, 8'h00);
      check("resume_hi1", seg_out, hex_tab[v[7:4]] | 8'h80);
      step(1'b1, 1'b0, 8'h00);
      check("resume_lo", seg_out, hex_tab[v[3:0]]);

      // 6. Async reset mid-GAP.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
      check("pre_rst_gap", {6'd0, phase}, 8'h03);
      async_reset();
      step(1'b1, 1'b0, 8'h00);
      check("post_rst_dash", seg_out, 8'h40);
      step(1'b1, 1'b0, 8'h00);
      check("post_rst_phase", {6'd0, phase}, 8'h00);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            async_reset();
         end
         step(($urandom_range(0, 7) != 0), ($urandom_range(0, 11) == 0),
              8'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
